ccg_bist_ctrl: RTL

//   Exhaustive stimulus/response engine for generated combinational CUTs.
//   On start, it drives every input vector 0..2^N_IN-1 onto the CUT inputs (x*).
//   It samples the CUT outputs (f*), streams each truth-table row out over a

---
 rtl/ccg_bist_ctrl_if.sv | 14 +
 rtl/ccg_bist_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/ccg_bist_ctrl_if.sv
// Truth-table row stream from the BIST controller to its downstream consumer.
// Rows move on the cycle where valid and ready are both high.
interface ccg_bist_ctrl_if #(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned N_OUT = 5
);
  logic             valid;
  logic             ready;
  logic [N_IN-1:0]  addr;
  logic [N_OUT-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/ccg_bist_ctrl.sv
// Exhaustive sweep engine for a combinational CUT: applies every input vector,
// streams each sampled response as a truth-table row and compacts them in a MISR.
module ccg_bist_ctrl #(
  parameter int unsigned      N_IN   = 5,
  parameter int unsigned      N_OUT  = 5,
  parameter int unsigned      SETTLE = 1,
  parameter logic [N_OUT-1:0] POLY   = N_OUT'(5'b00101)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_IN-1:0]    cut_x,
  input  logic [N_OUT-1:0]   cut_f,
  output logic               busy,
  output logic               done,
  output logic [N_OUT-1:0]   signature,
  ccg_bist_ctrl_if.master    tt
);

  localparam int unsigned     VecW    = N_IN + 1;
  localparam int unsigned     CntW    = 8;
  localparam logic [VecW-1:0] LastVec = VecW'(2 ** N_IN - 1);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StCapture, StDone} state_e;

  state_e           state;
  logic [VecW-1:0]  vec;
  logic [VecW-1:0]  vec_inc;
  logic [N_OUT-1:0] misr;
  logic [N_OUT-1:0] misr_nxt;
  logic [CntW-1:0]  cnt;
  logic             capture_en;

  assign vec_inc  = vec + 1'b1;
  assign misr_nxt = {misr[N_OUT-2:0], 1'b0} ^ (misr[N_OUT-1] ? POLY : '0) ^ cut_f;

  // The edge that enters CAPTURE is the only one that samples cut_f.
  assign capture_en = ((state == StApply) && (SETTLE == 0)) ||
                      ((state == StSettle) && (cnt <= CntW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      vec       <= '0;
      misr      <= '0;
      cnt       <= '0;
      cut_x     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= '0;
      tt.valid  <= 1'b0;
      tt.addr   <= '0;
      tt.data   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            vec   <= '0;
            misr  <= '0;
            cut_x <= '0;
            busy  <= 1'b1;
            state <= StApply;
          end
        end
        StApply: begin
          cnt   <= CntW'(SETTLE);
          state <= (SETTLE == 0) ? StCapture : StSettle;
        end
        StSettle: begin
          if (capture_en) begin
            state <= StCapture;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StCapture: begin
          if (tt.ready) begin
            tt.valid <= 1'b0;
            if (vec == LastVec) begin
              // misr already includes this row from its capture edge.
              signature <= misr;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= StDone;
            end else begin
              vec   <= vec_inc;
              cut_x <= vec_inc[N_IN-1:0];
              state <= StApply;
            end
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      if (capture_en) begin
        tt.valid <= 1'b1;
        tt.addr  <= vec[N_IN-1:0];
        tt.data  <= cut_f;
        misr     <= misr_nxt;
      end
    end
  end

endmodule
